// File: rtl/mem_data_skew_pkg.sv
// Shared constants and helpers for the memory-interface skew/deskew buffer.
// Lane delays are derived here so that the top level and any consumer agree on them.
package mem_data_skew_pkg;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

  // Number of {valid, data} stages per lane; covers the longest lane delay.
  function automatic int unsigned lane_depth(int unsigned array, int unsigned base_delay);
    return base_delay + array - 1;
  endfunction

  // Skew feeds array edges lane 0 first; deskew realigns with lane ARRAY-1 first.
  function automatic int unsigned lane_delay(int unsigned n, logic mode, int unsigned array,
                                             int unsigned base_delay);
    if (mode == MODE_DESKEW) begin
      return base_delay + array - 1 - n;
    end
    return base_delay + n;
  endfunction

  // Tap index runs 1..depth, so the select needs room for the value depth itself.
  function automatic int unsigned tap_width(int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_data_skew_if.sv
// Data-path bundle between the on-chip buffers / PE array and the skew buffer.
// The master drives the word and controls; the slave returns the skewed lanes and busy.
interface mem_data_skew_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY      = 32
);

  localparam int unsigned MEM_DATA_WIDTH = DATA_WIDTH * ARRAY;

  logic                      mode;
  logic                      enable;
  logic                      valid_in;
  logic [MEM_DATA_WIDTH-1:0] data_in;
  logic [ARRAY-1:0]          valid_out;
  logic [MEM_DATA_WIDTH-1:0] data_out;
  logic                      busy;

  modport master (
    output mode,
    output enable,
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  busy
  );

  modport slave (
    input  mode,
    input  enable,
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output busy
  );

endinterface

// File: rtl/mem_data_skew_lane.sv
// One lane of the skew buffer: a {valid, data} shift register with a selectable output tap.
// Tap k (1..DEPTH) exposes the word that has seen k enabled edges since acceptance.
module skew_lane
  import mem_data_skew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAP_W      = tap_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [TAP_W-1:0]      tap,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  any_valid
);

  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (enable) begin
      valid_q[0] <= valid_in;
      data_q[0]  <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Invalid stages still carry stale data, so the output is masked rather than passed through.
  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap == TAP_W'(i + 1) && valid_q[i]) begin
        valid_out = 1'b1;
        data_out  = data_q[i];
      end
    end
  end

  // Stages beyond the tap still count: their words must drain before a mode switch.
  assign any_valid = |valid_q;

endmodule

// File: rtl/mem_data_skew.sv
// Skew/deskew buffer for systolic-array memory interfaces: lane n of each word is delayed by a
// lane-dependent number of enabled cycles, with a mode switch that only takes effect when idle.
module mem_data_skew
  import mem_data_skew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ARRAY          = 32,
  parameter int unsigned BASE_DELAY     = 1,
  parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH * ARRAY
) (
  input logic            clk,
  input logic            reset,
  mem_data_skew_if.slave bus
);

  localparam int unsigned DEPTH = lane_depth(ARRAY, BASE_DELAY);
  localparam int unsigned TAP_W = tap_width(DEPTH);

  logic                      mode_q;
  logic                      eff_mode;
  logic                      busy;
  logic [ARRAY-1:0]          lane_busy;
  logic [ARRAY-1:0]          valid_out;
  logic [MEM_DATA_WIDTH-1:0] data_out;

  assign busy = |lane_busy;

  // While anything is in flight the mode is frozen so every queued word keeps its own delay.
  assign eff_mode = busy ? mode_q : bus.mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_SKEW;
    end else begin
      mode_q <= eff_mode;
    end
  end

  for (genvar n = 0; n < ARRAY; n++) begin : g_lane
    logic [TAP_W-1:0] tap;

    assign tap = TAP_W'(lane_delay(n, mode_q, ARRAY, BASE_DELAY));

    skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .TAP_W      (TAP_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .enable    (bus.enable),
      .tap       (tap),
      .valid_in  (bus.valid_in),
      .data_in   (bus.data_in[n*DATA_WIDTH +: DATA_WIDTH]),
      .valid_out (valid_out[n]),
      .data_out  (data_out[n*DATA_WIDTH +: DATA_WIDTH]),
      .any_valid (lane_busy[n])
    );
  end

  assign bus.valid_out = valid_out;
  assign bus.data_out  = data_out;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_mem_data_skew.sv
// Bench for mem_data_skew (ARRAY=4, DATA_WIDTH=8, BASE_DELAY=1): directed scenarios plus a
// random run, all checked against a word-level model of accepted words and their lane delays.
module tb_mem_data_skew;

  localparam int unsigned DW    = 8;
  localparam int unsigned AR    = 4;
  localparam int unsigned BD    = 1;
  localparam int unsigned DEPTH = BD + AR - 1;
  localparam int unsigned MW    = DW * AR;

  logic clk;
  logic reset;

  mem_data_skew_if #(.DATA_WIDTH(DW), .ARRAY(AR)) bus ();

  mem_data_skew #(
    .DATA_WIDTH     (DW),
    .ARRAY          (AR),
    .BASE_DELAY     (BD),
    .MEM_DATA_WIDTH (MW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: every accepted word with the enabled-edge count at acceptance and its mode.
  typedef struct {
    int unsigned   e;
    logic          m;
    logic [MW-1:0] d;
  } word_t;

  word_t       inflight[$];
  int unsigned ecount;
  logic        m_mode_q;
  int          n_cmp;
  int          n_fail;

  function automatic int unsigned delay_of(int unsigned n, logic m);
    return m ? (BD + AR - 1 - n) : (BD + n);
  endfunction

  task automatic model_edge();
    logic eff;
    if (reset) begin
      inflight.delete();
      ecount   = 0;
      m_mode_q = 1'b0;
      return;
    end
    eff      = (inflight.size() != 0) ? m_mode_q : bus.mode;
    m_mode_q = eff;
    if (bus.enable) begin
      if (bus.valid_in) inflight.push_back('{e: ecount, m: eff, d: bus.data_in});
      ecount++;
      while (inflight.size() != 0 && (ecount - inflight[0].e) > DEPTH) inflight.pop_front();
    end
  endtask

  function automatic void expect_out(output logic [AR-1:0] ev, output logic [MW-1:0] ed,
                                     output logic eb);
    ev = '0;
    ed = '0;
    eb = (inflight.size() != 0);
    foreach (inflight[i]) begin
      for (int unsigned n = 0; n < AR; n++) begin
        if ((ecount - inflight[i].e) == delay_of(n, inflight[i].m)) begin
          ev[n]          = 1'b1;
          ed[n*DW +: DW] = inflight[i].d[n*DW +: DW];
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic en, input logic v, input logic m,
                       input logic [MW-1:0] d);
    reset        = r;
    bus.enable   = en;
    bus.valid_in = v;
    bus.mode     = m;
    bus.data_in  = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    drive(1'b1, 1'b1, 1'b1, 1'b1, MW'($urandom));
    cycle();
    cycle();
    n_cmp++;
    if (bus.valid_out !== '0 || bus.data_out !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h busy=%b, want all zero",
               bus.valid_out, bus.data_out, bus.busy);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    expect_out(ev, ed, eb);
    n_cmp++;
    if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
               bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
    end
  endtask

  task automatic test_skew_single();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    logic [AR-1:0] xv;
    logic [MW-1:0] xd;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h4433_2211);
      else        drive(1'b0, 1'b1, 1'b0, 1'b0, MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL skew_single_model t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      xv = '0;
      xd = '0;
      if (t + 1 <= 4) begin
        xv                = AR'(1 << t);
        xd[t*DW +: DW]    = DW'(8'h11 * (t + 1));
      end
      n_cmp++;
      if (bus.valid_out !== xv || bus.data_out !== xd || bus.busy !== (t + 1 <= 4)) begin
        n_fail++;
        $display("FAIL skew_single t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, xv, xd, (t + 1 <= 4));
      end
    end
  endtask

  task automatic test_deskew();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    for (int t = 0; t < 12; t++) begin
      drive(1'b0, 1'b1, (t < 4), 1'b1, MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL deskew t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      if (t + 1 == 4) begin
        n_cmp++;
        if (bus.valid_out !== 4'hF) begin
          n_fail++;
          $display("FAIL deskew_aligned: got v=%b, want 1111", bus.valid_out);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    logic [MW-1:0] w;
    w = MW'($urandom);
    for (int t = 0; t < 10; t++) begin
      // The two edges closing cycles 1 and 2 are stalled; valid_in there must be ignored.
      if (t == 0)                drive(1'b0, 1'b1, 1'b1, 1'b0, w);
      else if (t == 1 || t == 2) drive(1'b0, 1'b0, 1'b1, 1'b0, MW'($urandom));
      else                       drive(1'b0, 1'b1, 1'b0, 1'b0, MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL stall t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      if (t + 1 >= 1 && t + 1 <= 3) begin
        n_cmp++;
        if (bus.valid_out !== 4'b0001 || bus.data_out !== {24'h0, w[7:0]}) begin
          n_fail++;
          $display("FAIL stall_hold t=%0d: got v=%b d=%h, want v=0001 d=%h",
                   t + 1, bus.valid_out, bus.data_out, {24'h0, w[7:0]});
        end
      end
      if (t + 1 == 4 || t + 1 == 6) begin
        n_cmp++;
        if (bus.valid_out !== AR'(1 << (t - 2)) ||
            bus.data_out[(t-2)*DW +: DW] !== w[(t-2)*DW +: DW]) begin
          n_fail++;
          $display("FAIL stall_lane t=%0d: got v=%b d=%h, want lane %0d = %h",
                   t + 1, bus.valid_out, bus.data_out, t - 2, w[(t-2)*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_mode_guard();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    for (int t = 0; t < 15; t++) begin
      drive(1'b0, 1'b1, (t == 0 || t == 8), (t >= 2), MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL mode_guard t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      // Skew order kept for the first word; deskew order for the second.
      if (t + 1 == 3 || t + 1 == 4 || t + 1 == 9 || t + 1 == 12) begin
        logic [AR-1:0] xv;
        case (t + 1)
          3:       xv = 4'b0100;
          4:       xv = 4'b1000;
          9:       xv = 4'b1000;
          default: xv = 4'b0001;
        endcase
        n_cmp++;
        if (bus.valid_out !== xv) begin
          n_fail++;
          $display("FAIL mode_guard_order t=%0d: got v=%b, want v=%b", t + 1, bus.valid_out, xv);
        end
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle();
  endtask

  task automatic test_reset_midstream();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    for (int t = 0; t < 11; t++) begin
      drive((t == 2), 1'b1, (t < 3), (t < 3), MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL reset_mid t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      if (t + 1 >= 3) begin
        n_cmp++;
        if (bus.valid_out !== '0 || bus.data_out !== '0 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_clear t=%0d: got v=%b d=%h busy=%b, want all zero",
                   t + 1, bus.valid_out, bus.data_out, bus.busy);
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    logic [AR-1:0] xv;
    logic [MW-1:0] xd;
    for (int t = 0; t < 16; t++) begin
      drive(1'b0, 1'b1, (t < 8), 1'b0, {AR{DW'(t + 1)}});
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL throughput t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t + 1, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
      xv = '0;
      xd = '0;
      for (int n = 0; n < AR; n++) begin
        if (t + 1 >= 1 + n && t + 1 <= 8 + n) begin
          xv[n]          = 1'b1;
          xd[n*DW +: DW] = DW'(t + 1 - n);
        end
      end
      n_cmp++;
      if (bus.valid_out !== xv || bus.data_out !== xd) begin
        n_fail++;
        $display("FAIL throughput_seq t=%0d: got v=%b d=%h, want v=%b d=%h",
                 t + 1, bus.valid_out, bus.data_out, xv, xd);
      end
    end
  endtask

  task automatic test_random();
    logic [AR-1:0] ev;
    logic [MW-1:0] ed;
    logic          eb;
    logic          m;
    m = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 7) == 0) m = ~m;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) < 6), m, MW'($urandom));
      cycle();
      expect_out(ev, ed, eb);
      n_cmp++;
      if (bus.valid_out !== ev || bus.data_out !== ed || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL random t=%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                 t, bus.valid_out, bus.data_out, bus.busy, ev, ed, eb);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    ecount   = 0;
    m_mode_q = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_skew_single();
    test_deskew();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    test_stall();
    test_mode_guard();
    test_reset_midstream();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_data_skew.md
# mem_data_skew

Parametrised skew/deskew buffer for systolic-array memory interfaces: lane n of a wide memory word is delayed by a lane-dependent number of cycles. Skew mode feeds array edges (lane 0 first); deskew mode realigns array outputs (lane ARRAY-1 first). It adds per-lane valid tracking, a global stall, synchronous reset, a configurable base delay and a busy-guarded mode switch. It sits between on-chip buffers and the PE array, on both the input and output side.

## Interface
- DATA_WIDTH, 8, bits per lane
- ARRAY, 32, lane count (≥1)
- BASE_DELAY, 1, minimum delay in cycles (≥1)
- MEM_DATA_WIDTH, DATA_WIDTH*ARRAY, packed word width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = skew, 1 = deskew; sampled only when idle
- enable  input  1  1 = advance all delay lines; 0 = hold all state (stall)
- valid_in  input  1  data_in is valid; accepted only when enable=1
- data_in  input  MEM_DATA_WIDTH  lane n at [n*DATA_WIDTH +: DATA_WIDTH]
- valid_out  output  ARRAY  per-lane valid
- data_out  output  MEM_DATA_WIDTH  delayed lanes; lane zeroed when its valid_out bit is 0
- busy  output  1  1 while any stage of any lane holds a valid word

## Operation
- Lane delay D(n): skew = BASE_DELAY + n; deskew = BASE_DELAY + ARRAY-1-n. Range BASE_DELAY to BASE_DELAY+ARRAY-1.
- Each lane: shift register of depth BASE_DELAY+ARRAY-1 of {valid, data}; output tap at stage D(n) chosen by mode_q.
- enable=1: every stage shifts one place; stage 1 loads {valid_in, data_in lane}. enable=0: nothing shifts, valid_in ignored, outputs held.
- mode_q: internal, register. Effective mode = busy ? mode_q : mode; mode_q <= effective mode every cycle. A mode change while busy=1 is ignored until the pipeline drains.
- busy = OR of valid bits over all stages of all lanes (registered state only, not valid_in).
- Data with valid 0 travels the pipe but is masked: data_out lane = valid_out[n] ? stage data : 0.
- reset: all stage valids and data cleared, mode_q = 0. Data in flight is dropped; no partial word emerges after reset.

## Timing
- Reset values: valid_out = 0, data_out = 0, busy = 0, mode_q = skew.
- A word accepted in cycle t (enable=1, valid_in=1) appears on lane n at the cycle after D(n) enabled edges. With enable held high, that is cycle t+D(n).
- Stall cycles add to latency one-for-one. Outputs are stable during a stall.
- Back-to-back words at one per enabled cycle; no bubbles inserted; throughput 1 word/cycle.
- busy rises the cycle after the first accepted word. It falls the cycle after the last valid leaves the deepest used tap. Stages beyond a lane's tap still count toward busy; their contents are shifted out and discarded.
- Reset has priority over enable. Reset asserted mid-stream clears everything on that edge.
- Mode applied to a word is the effective mode in its accept cycle.

## Structure
- Shared package: MODE_SKEW=1'b0, MODE_DESKEW=1'b1; function lane_delay(n, mode, ARRAY, BASE_DELAY); depth constant BASE_DELAY+ARRAY-1.
- Sub-module skew_lane: one lane's {valid, data} shift register with enable, reset and mux-selected tap. Parameters: DATA_WIDTH, DEPTH. Ports: clk, reset, enable, tap, valid_in, data_in, valid_out, data_out, any_valid.
- The top level generates ARRAY skew_lane instances, computes taps from mode_q, and ORs any_valid into busy.

## Test plan
All scenarios use ARRAY=4, DATA_WIDTH=8, BASE_DELAY=1.
- Skew, single word: mode=0, word {0x44,0x33,0x22,0x11} (lane3..0) at t=0, enable=1 -> lanes 0..3 valid only at t=1,2,3,4 with 0x11..0x44; data_out zero elsewhere; busy high t=1..4.
- Deskew, staggered: mode=1, lane 3 written at t=0, lane 2 at t=1, lane 1 at t=2, lane 0 at t=3 (other lanes invalid) -> all four lanes valid together at t=4.
- Stall: skew, word at t=0, enable=0 for t=2..3 -> lane 0 at t=1; lane 1 held invalid until t=4; lane 3 at t=6; outputs unchanged during stall.
- Mode guard: skew stream, mode=1 asserted at t=2 while busy -> skew delays kept. After busy falls, the next word uses deskew (lane 0 delay 4).
- Reset mid-stream: 3 back-to-back words from t=0, reset at t=2 -> from t=3 valid_out=0, data_out=0, busy=0, mode_q=0, and nothing emerges later.
- Throughput: 8 consecutive words 0x01..0x08 replicated per lane -> each lane emits 8 consecutive valid cycles in order, lane n starting at t=1+n.
